// File: rtl/reg_scoreboard_if.sv
// Issue / retire / status bundle between the decoder, writeback and the
// register hazard scoreboard.
//
// Handshake: the decoder presents an instruction with iss_valid; in the same
// cycle the scoreboard answers with iss_stall (hold everything) or iss_accept
// (instruction taken on the next rising edge). iss_accept is only ever high
// when iss_valid is high, iss_stall is low and flush is low. Retire ports
// (ret_en/ret_a) have no back-pressure: every enabled retire is consumed.
interface reg_scoreboard_if #(
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int RPORTS = 2,
    parameter int WPORTS = 2,
    parameter int CNTW   = 2
);
    logic                   iss_valid;
    logic [RPORTS*AW-1:0]   iss_rd_a;
    logic [RPORTS-1:0]      iss_rd_en;
    logic [WPORTS*AW-1:0]   iss_wr_a;
    logic [WPORTS-1:0]      iss_wr_en;
    logic                   iss_stall;
    logic                   iss_accept;
    logic [WPORTS*AW-1:0]   ret_a;
    logic [WPORTS-1:0]      ret_en;
    logic                   flush;
    logic [NREGS-1:0]       busy;
    logic [CNTW+AW-1:0]     outstanding;
    logic                   err;

    // Decoder / writeback / control side.
    modport master (
        output iss_valid, iss_rd_a, iss_rd_en, iss_wr_a, iss_wr_en,
        output ret_a, ret_en, flush,
        input  iss_stall, iss_accept, busy, outstanding, err
    );

    // Scoreboard side.
    modport slave (
        input  iss_valid, iss_rd_a, iss_rd_en, iss_wr_a, iss_wr_en,
        input  ret_a, ret_en, flush,
        output iss_stall, iss_accept, busy, outstanding, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard using per-register outstanding-write counters.
// A register is busy while any issued write to it has not yet retired.
// Stall is decided only from registered counters, so a retire never
// unblocks an issue in the same cycle.
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int RPORTS = 2,
    parameter int WPORTS = 2,
    parameter int CNTW   = 2
) (
    input logic              clk,
    input logic              rst,
    reg_scoreboard_if.slave  sb
);
    localparam int MAXCNT = (1 << CNTW) - 1;
    localparam int OW     = CNTW + AW;

    logic [CNTW-1:0] cnt     [NREGS];
    logic [CNTW-1:0] cnt_nxt [NREGS];
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_nxt;
    logic            err;
    logic            err_nxt;
    logic            stall_c;
    logic            accept_c;
    logic [NREGS-1:0] busy_c;

    // Hazard detection: RAW on any enabled source, or counter overflow on any
    // enabled destination counting duplicate destinations separately.
    always_comb begin
        logic            hazard;
        logic [AW-1:0]   a;
        logic [CNTW-1:0] c;
        int              req;
        hazard = 1'b0;
        a      = '0;
        c      = '0;
        req    = 0;
        for (int i = 0; i < RPORTS; i++) begin
            a = sb.iss_rd_a[i*AW +: AW];
            c = (int'(a) < NREGS) ? cnt[a] : '0;
            if (sb.iss_rd_en[i] && (c != '0)) hazard = 1'b1;
        end
        for (int j = 0; j < WPORTS; j++) begin
            a   = sb.iss_wr_a[j*AW +: AW];
            c   = (int'(a) < NREGS) ? cnt[a] : '0;
            req = 0;
            for (int m = 0; m < WPORTS; m++) begin
                if (sb.iss_wr_en[m] && (sb.iss_wr_a[m*AW +: AW] == a)) req = req + 1;
            end
            if (sb.iss_wr_en[j] && ((int'(c) + req) > MAXCNT)) hazard = 1'b1;
        end
        stall_c  = sb.iss_valid & hazard;
        accept_c = sb.iss_valid & ~hazard & ~sb.flush;
    end

    // Next counter values: net of accepted issues and retires, clamped at the
    // counter limits with the error flag raised on any clamp.
    always_comb begin
        int inc_sum;
        int dec_sum;
        int inc_r;
        int dec_r;
        int v;
        int out_v;
        inc_sum = 0;
        dec_sum = 0;
        inc_r   = 0;
        dec_r   = 0;
        v       = 0;
        err_nxt = err;
        for (int r = 0; r < NREGS; r++) begin
            inc_r = 0;
            dec_r = 0;
            for (int j = 0; j < WPORTS; j++) begin
                if (accept_c && sb.iss_wr_en[j] && (int'(sb.iss_wr_a[j*AW +: AW]) == r))
                    inc_r = inc_r + 1;
            end
            for (int k = 0; k < WPORTS; k++) begin
                if (sb.ret_en[k] && (int'(sb.ret_a[k*AW +: AW]) == r))
                    dec_r = dec_r + 1;
            end
            v = int'(cnt[r]) + inc_r - dec_r;
            if (v < 0) begin
                // Retire without matching issue: only the available count is removed.
                err_nxt = 1'b1;
                dec_r   = int'(cnt[r]) + inc_r;
                v       = 0;
            end else if (v > MAXCNT) begin
                err_nxt = 1'b1;
                v       = MAXCNT;
            end
            cnt_nxt[r] = v[CNTW-1:0];
            inc_sum    = inc_sum + inc_r;
            dec_sum    = dec_sum + dec_r;
        end
        out_v   = int'(outstanding) + inc_sum - dec_sum;
        out_nxt = out_v[OW-1:0];
    end

    // Tracking state: flush clears everything and wins over issue and retire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
            outstanding <= out_nxt;
            err         <= err_nxt;
        end
    end

    // Busy view of the registered counters.
    always_comb begin
        busy_c = '0;
        for (int r = 0; r < NREGS; r++) busy_c[r] = (cnt[r] != '0);
    end

    assign sb.iss_stall   = stall_c;
    assign sb.iss_accept  = accept_c;
    assign sb.busy        = busy_c;
    assign sb.outstanding = outstanding;
    assign sb.err         = err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a counter-array model checked every
// falling edge, plus literal checks at the interesting points of each scenario.
module tb_reg_scoreboard;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int CNTW   = 2;
    localparam int MAXCNT = 3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    reg_scoreboard_if #(.NREGS(NREGS), .AW(AW), .RPORTS(2), .WPORTS(2), .CNTW(CNTW)) sbif ();

    reg_scoreboard #(.NREGS(NREGS), .AW(AW), .RPORTS(2), .WPORTS(2), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: outstanding-write count per register, total, sticky error
    int m_cnt [NREGS];
    int m_out;
    int m_err;
    int inc_a [NREGS];
    int dec_a [NREGS];

    function automatic logic [AW-1:0] port_a(input logic [2*AW-1:0] bus, input int p);
        return bus[p*AW +: AW];
    endfunction

    // Compare process: outputs vs model, then advance model by one clock
    always @(negedge clk) begin
        logic            e_stall;
        logic            e_accept;
        logic [NREGS-1:0] e_busy;
        int              n;
        int              v;
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
            m_out = 0;
            m_err = 0;
        end
        e_stall = 1'b0;
        if (sbif.iss_valid) begin
            for (int i = 0; i < 2; i++)
                if (sbif.iss_rd_en[i] && m_cnt[port_a(sbif.iss_rd_a, i)] != 0) e_stall = 1'b1;
            for (int j = 0; j < 2; j++) begin
                n = 0;
                for (int m = 0; m < 2; m++)
                    if (sbif.iss_wr_en[m] && port_a(sbif.iss_wr_a, m) == port_a(sbif.iss_wr_a, j)) n++;
                if (sbif.iss_wr_en[j] && m_cnt[port_a(sbif.iss_wr_a, j)] + n > MAXCNT) e_stall = 1'b1;
            end
        end
        e_accept = sbif.iss_valid && !e_stall && !sbif.flush;
        for (int r = 0; r < NREGS; r++) e_busy[r] = (m_cnt[r] != 0);
        chk("busy", 64'(sbif.busy), 64'(e_busy));
        chk("outstanding", 64'(sbif.outstanding), 64'(m_out));
        chk("err", 64'(sbif.err), 64'(m_err));
        chk("iss_stall", 64'(sbif.iss_stall), 64'(e_stall));
        chk("iss_accept", 64'(sbif.iss_accept), 64'(e_accept));
        if (rst) begin
            if (sbif.flush) begin
                for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
                m_out = 0;
                m_err = 0;
            end else begin
                for (int r = 0; r < NREGS; r++) begin
                    inc_a[r] = 0;
                    dec_a[r] = 0;
                end
                for (int j = 0; j < 2; j++)
                    if (e_accept && sbif.iss_wr_en[j]) inc_a[port_a(sbif.iss_wr_a, j)]++;
                for (int k = 0; k < 2; k++)
                    if (sbif.ret_en[k]) dec_a[port_a(sbif.ret_a, k)]++;
                for (int r = 0; r < NREGS; r++) begin
                    v = m_cnt[r] + inc_a[r];
                    if (dec_a[r] > v) begin
                        m_err = 1;
                        dec_a[r] = v;
                    end
                    v = v - dec_a[r];
                    if (v > MAXCNT) begin
                        m_err = 1;
                        v = MAXCNT;
                    end
                    m_cnt[r] = v;
                    m_out = m_out + inc_a[r] - dec_a[r];
                end
            end
        end
    end

    // Driver tasks
    task automatic clr();
        sbif.iss_valid = 1'b0;
        sbif.iss_rd_a  = '0;
        sbif.iss_rd_en = '0;
        sbif.iss_wr_a  = '0;
        sbif.iss_wr_en = '0;
        sbif.ret_a     = '0;
        sbif.ret_en    = '0;
        sbif.flush     = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic iss(input logic [1:0] rd_en, input int rd0, input int rd1,
                       input logic [1:0] wr_en, input int wr0, input int wr1);
        sbif.iss_valid = 1'b1;
        sbif.iss_rd_en = rd_en;
        sbif.iss_rd_a  = {5'(rd1), 5'(rd0)};
        sbif.iss_wr_en = wr_en;
        sbif.iss_wr_a  = {5'(wr1), 5'(wr0)};
    endtask

    task automatic ret(input logic [1:0] en, input int a0, input int a1);
        sbif.ret_en = en;
        sbif.ret_a  = {5'(a1), 5'(a0)};
    endtask

    // Directed scenarios
    initial begin
        rst = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Out of reset: nothing busy, issue goes straight through
        cyc(); iss(2'b01, 0, 0, 2'b00, 0, 0); settle();
        chk("reset_busy", 64'(sbif.busy), 64'd0);
        chk("reset_out", 64'(sbif.outstanding), 64'd0);
        chk("reset_accept", 64'(sbif.iss_accept), 64'd1);

        // RAW on r5, retire in cycle 3, accept in cycle 4
        cyc(); iss(2'b00, 0, 0, 2'b01, 5, 0); settle();
        chk("r5_wr_accept", 64'(sbif.iss_accept), 64'd1);
        cyc(); iss(2'b01, 5, 0, 2'b00, 0, 0); settle();
        chk("r5_c1_stall", 64'(sbif.iss_stall), 64'd1);
        chk("r5_c1_busy", 64'(sbif.busy[5]), 64'd1);
        cyc(); iss(2'b01, 5, 0, 2'b00, 0, 0); settle();
        chk("r5_c2_stall", 64'(sbif.iss_stall), 64'd1);
        cyc(); iss(2'b01, 5, 0, 2'b00, 0, 0); ret(2'b01, 5, 0); settle();
        chk("r5_c3_stall_with_ret", 64'(sbif.iss_stall), 64'd1);
        cyc(); iss(2'b01, 5, 0, 2'b00, 0, 0); settle();
        chk("r5_c4_accept", 64'(sbif.iss_accept), 64'd1);
        chk("r5_c4_busy", 64'(sbif.busy[5]), 64'd0);

        // Duplicate destination r7 on both ports
        cyc(); iss(2'b00, 0, 0, 2'b11, 7, 7); settle();
        chk("r7_dup_accept", 64'(sbif.iss_accept), 64'd1);
        cyc(); settle();
        chk("r7_busy", 64'(sbif.busy[7]), 64'd1);
        chk("r7_out2", 64'(sbif.outstanding), 64'd2);
        cyc(); ret(2'b11, 7, 7);
        cyc(); settle();
        chk("r7_cleared", 64'(sbif.busy[7]), 64'd0);
        chk("r7_out0", 64'(sbif.outstanding), 64'd0);

        // Counter saturation on r2
        repeat (3) begin
            cyc(); iss(2'b00, 0, 0, 2'b01, 2, 0);
        end
        cyc(); iss(2'b00, 0, 0, 2'b01, 2, 0); ret(2'b01, 2, 0); settle();
        chk("r2_full_stall", 64'(sbif.iss_stall), 64'd1);
        chk("r2_full_out", 64'(sbif.outstanding), 64'd3);
        cyc(); iss(2'b00, 0, 0, 2'b01, 2, 0); settle();
        chk("r2_next_accept", 64'(sbif.iss_accept), 64'd1);
        chk("r2_out_after_ret", 64'(sbif.outstanding), 64'd2);
        cyc(); settle();
        chk("r2_back_to_3", 64'(sbif.outstanding), 64'd3);
        cyc(); ret(2'b01, 2, 0);
        cyc(); iss(2'b00, 0, 0, 2'b11, 2, 2); settle();
        chk("r2_dup_overflow_stall", 64'(sbif.iss_stall), 64'd1);
        cyc(); ret(2'b11, 2, 2);
        cyc(); settle();
        chk("r2_drained", 64'(sbif.outstanding), 64'd0);

        // Retire without issue: sticky error, cleared by flush
        cyc(); ret(2'b01, 9, 0);
        cyc(); settle();
        chk("r9_err_set", 64'(sbif.err), 64'd1);
        chk("r9_no_underflow", 64'(sbif.busy[9]), 64'd0);
        cyc(); iss(2'b00, 0, 0, 2'b10, 0, 12);
        cyc(); iss(2'b10, 0, 12, 2'b00, 0, 0); settle();
        chk("r12_port1_stall", 64'(sbif.iss_stall), 64'd1);
        chk("err_sticky", 64'(sbif.err), 64'd1);
        cyc(); iss(2'b10, 0, 12, 2'b00, 0, 0); ret(2'b10, 0, 12);
        cyc(); iss(2'b10, 0, 12, 2'b00, 0, 0); settle();
        chk("r12_accept", 64'(sbif.iss_accept), 64'd1);
        cyc(); sbif.flush = 1'b1;
        cyc(); settle();
        chk("flush_clears_err", 64'(sbif.err), 64'd0);

        // Flush beats same-cycle issue and retire
        cyc(); iss(2'b00, 0, 0, 2'b01, 1, 0);
        cyc(); iss(2'b00, 0, 0, 2'b01, 4, 0); ret(2'b01, 1, 0); sbif.flush = 1'b1; settle();
        chk("flush_no_accept", 64'(sbif.iss_accept), 64'd0);
        cyc(); settle();
        chk("flush_busy", 64'(sbif.busy), 64'd0);
        chk("flush_out", 64'(sbif.outstanding), 64'd0);

        // Asynchronous reset in the middle of traffic
        cyc(); ret(2'b01, 9, 0);
        cyc(); iss(2'b00, 0, 0, 2'b11, 3, 3);
        cyc(); iss(2'b00, 0, 0, 2'b01, 10, 0); settle();
        chk("pre_rst_out", 64'(sbif.outstanding), 64'd2);
        chk("pre_rst_busy3", 64'(sbif.busy[3]), 64'd1);
        chk("pre_rst_err", 64'(sbif.err), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(sbif.busy), 64'd0);
        chk("async_rst_out", 64'(sbif.outstanding), 64'd0);
        chk("async_rst_err", 64'(sbif.err), 64'd0);
        cyc(); rst = 1'b1;
        cyc(); iss(2'b01, 3, 0, 2'b00, 0, 0); settle();
        chk("post_rst_accept", 64'(sbif.iss_accept), 64'd1);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register hazard scoreboard between the instruction decoder and the execute/memory/writeback stages. It replaces purely combinational address comparison against each downstream stage with per-register outstanding-write counters. Issue is therefore independent of pipeline depth, and several writes to one register may be in flight at once. The decoder raises an issue request, the scoreboard answers stall/accept in the same cycle, and the writeback stage (or a squashed conditional instruction) retires destinations.

## Interface

Parameters:
- NREGS, 32, number of architectural registers tracked (all indices 0..NREGS-1 are real registers).
- AW, 5, register address width; NREGS <= 2^AW.
- RPORTS, 2, source-register ports per issued instruction.
- WPORTS, 2, destination-register ports per issued instruction, and retire ports per cycle.
- CNTW, 2, per-register counter width; MAXCNT = 2^CNTW-1 outstanding writes per register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- iss_valid  in  1  decoder presents an instruction.
- iss_rd_a  in  RPORTS*AW  source addresses; port i occupies bits [i*AW +: AW].
- iss_rd_en  in  RPORTS  source port i is read.
- iss_wr_a  in  WPORTS*AW  destination addresses, packed the same way.
- iss_wr_en  in  WPORTS  destination port j is written.
- iss_stall  out  1  combinational; instruction must be held.
- iss_accept  out  1  combinational; iss_valid & ~iss_stall & ~flush.
- ret_a  in  WPORTS*AW  retiring destination addresses.
- ret_en  in  WPORTS  retire port k is active; covers both committed writes and squashed (cres=0) writes.
- flush  in  1  synchronous clear of all tracking.
- busy  out  NREGS  bit r = (cnt[r] != 0), combinational from registered state.
- outstanding  out  CNTW+AW  sum of all cnt[r], registered.
- err  out  1  sticky underflow/overflow flag, registered.

## Operation

- State: cnt[0..NREGS-1], CNTW bits each; outstanding; err.
- Per cycle, for each r:
  - inc[r] = number of ports j with iss_accept & iss_wr_en[j] & (wr_a[j]==r). Duplicate destinations count separately, so inc can be 2.
  - dec[r] = number of ports k with ret_en[k] & (ret_a[k]==r).
- iss_stall is asserted when iss_valid and either:
  - any enabled source has cnt != 0 (RAW hazard), or
  - any enabled destination r has cnt[r] + (its requested inc, computed as if accepted) > MAXCNT.
- Stall uses current registered cnt only. A retire in the same cycle does not clear the stall; there is no bypass.
- iss_stall is 0 when iss_valid=0.
- Update with flush=0: cnt[r] <= cnt[r] + inc[r] - dec[r], computed at CNTW+2 bits.
  - If the result is < 0: cnt[r] <= 0 and err <= 1 (retire without issue).
  - If the result is > MAXCNT: cnt[r] <= MAXCNT and err <= 1. This cannot happen with legal stall use.
- outstanding <= outstanding + Σinc - Σ(dec actually applied, after clamping).
- Update with flush=1: all cnt <= 0, outstanding <= 0, err <= 0. Flush dominates same-cycle issue (iss_accept=0) and retire.
- Same-cycle issue and retire of one register: net effect applied; cnt unchanged if inc=dec=1.

## Timing

- Reset (rst=0, asynchronous): all cnt=0, outstanding=0, err=0. Hence busy=0, iss_stall=0, and iss_accept=iss_valid. Holds until rst rises; reset mid-operation discards all in-flight tracking.
- Issue-to-busy latency: 1 cycle. Register r is busy starting the cycle after acceptance.
- Retire-to-clear latency: 1 cycle. A source stalled on r is accepted in the cycle after the last retire of r.
- Handshake: the decoder holds all iss_* inputs stable while iss_stall=1. The scoreboard does not require it, since stall is re-evaluated every cycle.
- No combinational path from ret_* to iss_stall or iss_accept.
- Combinational paths from iss_* to iss_stall/iss_accept are allowed. Only flush, iss_* and state feed iss_accept.

## Test plan

- Reset with rst=0 mid-traffic (cnt[3]=2): busy=0, outstanding=0, err=0 immediately, without waiting for a clock edge.
- Issue wr r5 at cycle 0; at cycle 1 issue rd r5 -> stall=1. ret r5 at cycle 3 -> stall still 1 in cycle 3, accept in cycle 4, busy[5]=0 from cycle 4.
- Issue wr_a={r7,r7} both enabled -> cnt[7]=2, outstanding=2. Retire r7 on both ports in one cycle -> cnt[7]=0.
- CNTW=2: three accepted writes to r2 (cnt=3), fourth issue to r2 -> stall=1. Same cycle ret r2 -> cnt stays 3, accept next cycle, cnt returns to 3.
- Retire r9 with cnt[9]=0 -> cnt[9]=0, err=1 sticky. A later flush -> err=0.
- flush asserted with iss_valid=1 writing r4 and ret r1 (cnt[1]=1) -> iss_accept=0, next cycle all cnt=0, outstanding=0.
